us_range_sched: RTL and testbench
=================================

Name: us_range_sched

Overview:
Round-robin measurement scheduler for up to NUM_SENS ultrasonic ranging sensors that share one echo-timing datapath. Per slot, for one enabled sensor, it:
- fires a fixed-width trigger pulse,
- waits for the echo rising edge,
- times the echo high width in clk cycles, with timeouts,
- reports one tagged result,
- holds a guard interval before the next sensor, to prevent acoustic crosstalk.
It sits between the sensor pins and the distance-conversion / host-register logic.

Parameters:
NUM_SENS, 4, number of sensors (2..8)
TRIG_CYC, 480, trigger high width in clk cycles (10 us at 48 MHz)
RISE_TMO_CYC, 48000, max cycles from trigger end to echo rise
ECHO_MAX_CYC, 1200000, max echo high width in cycles before overflow
GUARD_CYC, 480000, quiet cycles after each slot
CNT_W, 32, width of the cycle counter and of meas_cycles

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
en  in  1  run enable
sens_mask  in  NUM_SENS  per-sensor enable
trig  out  NUM_SENS  one-hot trigger outputs
echo  in  NUM_SENS  raw asynchronous echo inputs
meas_valid  out  1  one-cycle result strobe
meas_id  out  $clog2(NUM_SENS)  sensor index of the result
meas_cycles  out  CNT_W  measured echo width in cycles
meas_status  out  2  result status: 00 OK, 01 NO_ECHO, 10 OVERFLOW
busy  out  1  high in every state except IDLE

Behaviour:
Reset values:
- All outputs 0; state IDLE.
- last_id = NUM_SENS-1, so the first slot serves sensor 0.
- Synchronizers cleared.

Echo input path:
- Each echo bit passes a 2-flop synchronizer, then a registered edge detector.
- Only synchronized values are used.

State machine:
- IDLE: if en=1 and sens_mask!=0, go to SELECT. Otherwise stay.
- SELECT (1 cycle):
  - Latch cur_id = next set bit of sens_mask strictly after last_id, wrapping modulo NUM_SENS.
  - Set last_id = cur_id. Clear cnt. Go to TRIG.
  - If sens_mask==0 at this cycle, go to IDLE.
- TRIG: trig[cur_id]=1 for exactly TRIG_CYC cycles, all other trig bits 0. Then clear cnt and go to WAIT_RISE.
- WAIT_RISE:
  - Wait for a rising edge on sync echo[cur_id]. An echo already high on entry is not a rise.
  - On the rise, set cnt=1 and go to MEASURE.
  - If RISE_TMO_CYC cycles pass with no rise, post NO_ECHO with meas_cycles=0 and go to GUARD.
  - If the rise lands on the timeout cycle, the rise wins.
- MEASURE:
  - Increment cnt each cycle sync echo is 1.
  - On the falling edge, post OK with meas_cycles = cnt, which equals the synchronized high width exactly. Go to GUARD.
  - If cnt reaches ECHO_MAX_CYC while echo is still high, post OVERFLOW with meas_cycles=ECHO_MAX_CYC and go to GUARD.
- GUARD: count GUARD_CYC cycles. Then go to SELECT if en=1, else IDLE.

Result posting:
- meas_valid is a single-cycle pulse, registered in the cycle after the deciding event.
- meas_id, meas_cycles and meas_status update in that same cycle and hold until the next post.
- Exactly one post per slot.

Enable and mask changes:
- en is only sampled in IDLE and at the end of GUARD. Dropping en mid-slot completes the slot, including its post and guard. No trigger pulse is ever truncated.
- sens_mask is sampled only in SELECT. A mask change mid-slot affects the next selection only.
- Echo activity on non-selected sensors is ignored.

Reset and counters:
- rst mid-operation aborts immediately to reset values: trig drops in the same clock edge, and no post occurs.
- Counters saturate and never wrap. CNT_W must hold max(ECHO_MAX_CYC, GUARD_CYC, RISE_TMO_CYC).

Decomposition:
Shared package us_range_pkg contains:
- state enum (IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, GUARD)
- status constants ST_OK, ST_NO_ECHO, ST_OVERFLOW
- default timing constants at 48 MHz
Natural sub-module: us_echo_sync.
- Per-bit 2-flop synchronizer plus rise/fall strobes.
- Instantiated NUM_SENS wide.
The next-set-bit round-robin picker stays inside the top module as a function.

Test Plan:
1. mask=4'b1111, en=1, each echo a 2400-cycle pulse 100 cycles after trig end -> posts for ids 0,1,2,3,0 in order; each is OK with meas_cycles=2400; trig high exactly 480 cycles, one-hot.
2. mask=4'b0101, no echo on sensor 2 -> id0 OK, then id2 NO_ECHO with cycles=0 exactly 48000 cycles after its trig end, then id0 again.
3. echo[1] held high permanently, mask=4'b0010 -> first slot NO_ECHO, because high-on-entry is not a rise.
4. echo[1] rises and stays high -> OVERFLOW with cycles=1200000.
5. en dropped 10 cycles into TRIG -> trig still completes 480 cycles; the slot posts normally; IDLE after GUARD; busy=0.
6. rst asserted in MEASURE -> next cycle all trig=0, meas_valid=0, busy=0; after release, first slot serves id 0.
7. Echo rise on exactly the RISE_TMO_CYC-th cycle -> measured as OK, not NO_ECHO.
8. mask changed from 4'b0011 to 4'b1000 during the id0 slot -> next post id=3.

Source files
------------

// File: rtl/us_range_pkg.sv
// Shared types and 48 MHz timing defaults for the ultrasonic range scheduler.
package us_range_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GUARD
  } state_t;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NO_ECHO  = 2'b01;
  localparam logic [1:0] ST_OVERFLOW = 2'b10;

  localparam int DEF_NUM_SENS     = 4;
  localparam int DEF_TRIG_CYC     = 480;
  localparam int DEF_RISE_TMO_CYC = 48000;
  localparam int DEF_ECHO_MAX_CYC = 1200000;
  localparam int DEF_GUARD_CYC    = 480000;
  localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/us_echo_sync.sv
// Two-flop echo synchronizer with registered rise/fall strobes.
module us_echo_sync
  import us_range_pkg::*;
#(
  parameter int W = DEF_NUM_SENS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] echo_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/us_range_sched.sv
// Round-robin trigger/echo scheduler for a bank of ultrasonic rangers.
module us_range_sched
  import us_range_pkg::*;
#(
  parameter int NUM_SENS     = DEF_NUM_SENS,
  parameter int TRIG_CYC     = DEF_TRIG_CYC,
  parameter int RISE_TMO_CYC = DEF_RISE_TMO_CYC,
  parameter int ECHO_MAX_CYC = DEF_ECHO_MAX_CYC,
  parameter int GUARD_CYC    = DEF_GUARD_CYC,
  parameter int CNT_W        = DEF_CNT_W,
  localparam int IDW         = $clog2(NUM_SENS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [NUM_SENS-1:0] sens_mask_i,
  output logic [NUM_SENS-1:0] trig_o,
  input  logic [NUM_SENS-1:0] echo_i,
  output logic                meas_valid_o,
  output logic [IDW-1:0]      meas_id_o,
  output logic [CNT_W-1:0]    meas_cycles_o,
  output logic [1:0]          meas_status_o,
  output logic                busy_o
);

  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(RISE_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] ECHO_MAX   = CNT_W'(ECHO_MAX_CYC);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  state_t              state_q, state_d;
  logic [IDW-1:0]      cur_q, cur_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      pick;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [NUM_SENS-1:0] trig_q, trig_d;
  logic [NUM_SENS-1:0] rise, fall;
  logic                valid_q, valid_d;
  logic [1:0]          status_q, status_d;

  // First set mask bit strictly after last, wrapping around.
  function automatic logic [IDW-1:0] next_id(
    input logic [NUM_SENS-1:0] m,
    input logic [IDW-1:0]      last
  );
    int   idx;
    logic found;
    next_id = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_SENS; i++) begin
      idx = (int'(last) + i) % NUM_SENS;
      if (!found && m[IDW'(idx)]) begin
        next_id = IDW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  us_echo_sync #(
    .W(NUM_SENS)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .echo_i (echo_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign pick    = next_id(sens_mask_i, last_q);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    trig_d   = '0;
    valid_d  = 1'b0;
    id_d     = id_q;
    cyc_d    = cyc_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (en_i && |sens_mask_i) state_d = SELECT;
      end
      SELECT: begin
        if (|sens_mask_i) begin
          cur_d        = pick;
          last_d       = pick;
          cnt_d        = '0;
          trig_d[pick] = 1'b1;
          state_d      = TRIG;
        end else begin
          state_d = IDLE;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end else begin
          cnt_d  = cnt_inc;
          trig_d = trig_q;
        end
      end
      WAIT_RISE: begin
        // A rise seen on the final timeout cycle still counts.
        if (rise[cur_q]) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end else if (cnt_q == TMO_LAST) begin
          valid_d  = 1'b1;
          id_d     = cur_q;
          cyc_d    = '0;
          status_d = ST_NO_ECHO;
          cnt_d    = '0;
          state_d  = GUARD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEASURE: begin
        if (fall[cur_q]) begin
          valid_d  = 1'b1;
          id_d     = cur_q;
          cyc_d    = cnt_q;
          status_d = ST_OK;
          cnt_d    = '0;
          state_d  = GUARD;
        end else if (cnt_q >= ECHO_MAX) begin
          valid_d  = 1'b1;
          id_d     = cur_q;
          cyc_d    = ECHO_MAX;
          status_d = ST_OVERFLOW;
          cnt_d    = '0;
          state_d  = GUARD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = en_i ? SELECT : IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= IDW'(NUM_SENS - 1);
      cnt_q    <= '0;
      trig_q   <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      cyc_q    <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      cyc_q    <= cyc_d;
      status_q <= status_d;
    end
  end

  assign trig_o        = trig_q;
  assign meas_valid_o  = valid_q;
  assign meas_id_o     = id_q;
  assign meas_cycles_o = cyc_q;
  assign meas_status_o = status_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_us_range_sched.sv
// Scoreboard bench: sensor model predicts each slot's post, monitor checks.
module tb_us_range_sched;
  import us_range_pkg::*;

  localparam int NS    = 4;
  localparam int TRIG  = 20;
  localparam int TMO   = 60;
  localparam int EMAX  = 150;
  localparam int GUARD = 40;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [NS-1:0] mask = '0;
  logic [NS-1:0] trig;
  logic [NS-1:0] echo;
  logic [NS-1:0] echo_drv = '0;
  logic [NS-1:0] echo_stuck = '0;
  logic          mv;
  logic [1:0]    mid;
  logic [CW-1:0] mcyc;
  logic [1:0]    mst;
  logic          busy;

  assign echo = echo_drv | echo_stuck;

  us_range_sched #(
    .NUM_SENS     (NS),
    .TRIG_CYC     (TRIG),
    .RISE_TMO_CYC (TMO),
    .ECHO_MAX_CYC (EMAX),
    .GUARD_CYC    (GUARD),
    .CNT_W        (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .sens_mask_i   (mask),
    .trig_o        (trig),
    .echo_i        (echo),
    .meas_valid_o  (mv),
    .meas_id_o     (mid),
    .meas_cycles_o (mcyc),
    .meas_status_o (mst),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     id;
    int     st;
    int     cyc;
    longint t;
  } exp_t;

  typedef struct {
    int j;
    int w;
  } plan_t;

  exp_t   exp_q[$];
  plan_t  plan_q[$];
  int     checks = 0;
  int     errors = 0;
  int     posts = 0;
  int     slots = 0;
  int     model_last = NS - 1;
  bit     noise = 1'b0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int rr_next(logic [NS-1:0] m, int last);
    int r;
    bit found;
    r = last;
    found = 1'b0;
    for (int i = 1; i <= NS; i++) begin
      if (!found && ((m >> ((last + i) % NS)) & 1) != 0) begin
        r = (last + i) % NS;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Sensor model: on each slot predict the result and play the echo.
  initial begin : sensor
    int id, eid, len, nlen;
    bit oh;
    plan_t p;
    exp_t e;
    longint t0;
    logic [NS-1:0] bitv;
    forever begin
      @(posedge clk); #1;
      if (rst || trig == '0) continue;
      slots++;
      eid = rr_next(mask, model_last);
      model_last = eid;
      id = -1;
      for (int k = 0; k < NS; k++)
        if (trig == (NS'(1) << k)) id = k;
      chk("trig_id", id, eid);
      oh = 1'b1;
      len = 1;
      while (!rst && len < 4 * TRIG) begin
        @(posedge clk); #1;
        if (trig == '0) break;
        if (trig != (NS'(1) << eid)) oh = 1'b0;
        len++;
      end
      if (rst) continue;
      chk("trig_len", len, TRIG);
      chk("trig_onehot", longint'(oh), 1);
      t0 = cyc;
      if (plan_q.size() > 0) begin
        p = plan_q.pop_front();
      end else begin
        case ($urandom_range(0, 9))
          0: begin p.j = 0; p.w = 0; end
          1: begin
            p.j = $urandom_range(0, TMO - 3);
            p.w = EMAX + 5 + $urandom_range(0, 10);
          end
          default: begin
            p.j = $urandom_range(0, TMO - 3);
            p.w = $urandom_range(1, EMAX);
          end
        endcase
      end
      e.id = eid;
      if (p.w == 0 || ((echo_stuck >> eid) & 1) != 0 || p.j + 2 >= TMO) begin
        e.st = ST_NO_ECHO; e.cyc = 0; e.t = t0 + TMO;
      end else if (p.w > EMAX) begin
        e.st = ST_OVERFLOW; e.cyc = EMAX; e.t = t0 + p.j + EMAX + 3;
      end else begin
        e.st = ST_OK; e.cyc = p.w; e.t = t0 + p.j + p.w + 3;
      end
      exp_q.push_back(e);
      nlen = (p.w == 0) ? TMO : p.j + p.w;
      bitv = NS'(1) << eid;
      for (int n = 0; n < nlen && !rst; n++) begin
        echo_drv = ((n >= p.j && n < p.j + p.w) ? bitv : '0)
                 | (noise ? (NS'($urandom) & ~bitv) : '0);
        @(posedge clk); #1;
      end
      echo_drv = '0;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mv) begin
        posts++;
        chk("post_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("meas_id", longint'(mid), e.id);
          chk("meas_status", longint'(mst), e.st);
          chk("meas_cycles", longint'(mcyc), e.cyc);
          chk("post_time", cyc, e.t);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_slots(int target);
    int b = 0;
    while (slots < target && b < 4000) begin
      @(negedge clk);
      b++;
    end
    chk("slots_started", slots, target);
  endtask

  task automatic wait_done(int target);
    int b = 0;
    while ((posts < target || busy) && b < 4000) begin
      @(negedge clk);
      b++;
    end
    chk("posts_done", posts, target);
    chk("idle_busy", longint'(busy), 0);
  endtask

  task automatic run_slots(int n, int drop_dly);
    int ts = slots + n;
    int tp = posts + n;
    @(negedge clk);
    en = 1'b1;
    wait_slots(ts);
    repeat (drop_dly) @(negedge clk);
    en = 1'b0;
    wait_done(tp);
  endtask

  initial begin : main
    int b;
    int ts, tp;
    repeat (3) @(negedge clk);
    chk("rst_trig", longint'(trig), 0);
    chk("rst_valid", longint'(mv), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_id", longint'(mid), 0);
    chk("rst_cycles", longint'(mcyc), 0);
    chk("rst_status", longint'(mst), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mask = 4'b1111;
    repeat (5) plan_q.push_back('{j: 10, w: 100});
    run_slots(5, 0);

    mask = 4'b0101;
    plan_q.push_back('{j: 0, w: 0});
    plan_q.push_back('{j: 10, w: 100});
    plan_q.push_back('{j: 0, w: 0});
    run_slots(3, 0);

    mask = 4'b0010;
    echo_stuck = 4'b0010;
    repeat (5) @(negedge clk);
    plan_q.push_back('{j: 5, w: 50});
    run_slots(1, 0);
    echo_stuck = '0;
    repeat (5) @(negedge clk);

    plan_q.push_back('{j: 5, w: EMAX + 15});
    run_slots(1, 0);

    mask = 4'b1111;
    plan_q.push_back('{j: 10, w: 100});
    run_slots(1, 10);
    repeat (GUARD) @(negedge clk);
    chk("en_drop_idle", longint'(busy), 0);

    mask = 4'b0001;
    plan_q.push_back('{j: TMO - 3, w: 30});
    plan_q.push_back('{j: TMO - 2, w: 5});
    run_slots(2, 0);

    mask = 4'b0100;
    plan_q.push_back('{j: 5, w: 100});
    ts = slots + 1;
    en = 1'b1;
    wait_slots(ts);
    en = 1'b0;
    b = 0;
    while (trig != '0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_trig", longint'(trig), 0);
    chk("mrst_valid", longint'(mv), 0);
    chk("mrst_busy", longint'(busy), 0);
    chk("mrst_cycles", longint'(mcyc), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    plan_q.delete();
    model_last = NS - 1;
    @(negedge clk);

    mask = 4'b0011;
    plan_q.push_back('{j: 10, w: 50});
    plan_q.push_back('{j: 10, w: 50});
    ts = slots + 1;
    tp = posts + 2;
    en = 1'b1;
    wait_slots(ts);
    mask = 4'b1000;
    wait_slots(ts + 1);
    en = 1'b0;
    wait_done(tp);

    noise = 1'b1;
    for (int r = 0; r < 4; r++) begin
      mask = NS'($urandom_range(1, 15));
      run_slots(4, 0);
    end
    noise = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
